// File: rtl/a_matrix_sampler.sv
// a_matrix_sampler: rejection sampler that turns the XOF byte stream into the
// public matrix A. Three bytes give two 12-bit candidates, and only values
// below Q are written out. The upstream XOF is reseeded once per polynomial.
// Optional build macro A_SAMPLER_STATS_EN adds reject/byte counters.
module a_matrix_sampler #(
   parameter int Kyber_Security = 3,
   parameter int Q              = 3329
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        xof_restart,
   output logic [2:0]  xof_outer,
   output logic [2:0]  xof_inner,
   output logic        write_enable,
   output logic [7:0]  i,
   output logic [2:0]  inner_loop,
   output logic [2:0]  outer_loop,
   output logic [15:0] data_out,
   output logic        done
`ifdef A_SAMPLER_STATS_EN
   ,output logic [15:0] reject_count,
   output logic [15:0] byte_count
`endif
);

   typedef enum logic [3:0] {IDLE, SEED, B0, B1, B2, EMIT1, EMIT2, NEXT, DONE} state_t;

   localparam logic [11:0] QV   = 12'(Q);
   localparam logic [2:0]  KMAX = 3'(Kyber_Security - 1);

   state_t      state_q, state_d;
   logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [2:0]  inner_q, inner_d, outer_q, outer_d;
   logic        byte_ready_q, byte_ready_d, xof_restart_q, xof_restart_d;
   logic [2:0]  xof_outer_q, xof_outer_d, xof_inner_q, xof_inner_d;
   logic        write_enable_q, write_enable_d, done_q, done_d;
   logic [7:0]  i_q, i_d;
   logic [15:0] data_out_q, data_out_d;
   logic        hs, acc1, acc2;
   logic [11:0] d1, d2;
`ifdef A_SAMPLER_STATS_EN
   logic [15:0] rej_q, rej_d, bcnt_q, bcnt_d;
`endif

   // d1 is formed while b2 is still on the bus; d2 once b2 has been latched
   assign hs   = byte_valid && byte_ready_q;
   assign d1   = {b1_q[3:0], b0_q};
   assign d2   = {b2_q, b1_q[7:4]};
   assign acc1 = (d1 < QV);
   assign acc2 = (d2 < QV) && !cnt_q[8];

   // next-state and registered-output computation
   always_comb begin
      state_d        = state_q;
      b0_d           = b0_q;
      b1_d           = b1_q;
      b2_d           = b2_q;
      cnt_d          = cnt_q;
      inner_d        = inner_q;
      outer_d        = outer_q;
      byte_ready_d   = 1'b0;
      xof_restart_d  = 1'b0;
      xof_outer_d    = xof_outer_q;
      xof_inner_d    = xof_inner_q;
      write_enable_d = 1'b0;
      i_d            = i_q;
      data_out_d     = data_out_q;
      done_d         = done_q;
`ifdef A_SAMPLER_STATS_EN
      rej_d          = rej_q;
      bcnt_d         = (hs && bcnt_q != 16'hFFFF) ? bcnt_q + 16'd1 : bcnt_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d       = SEED;
               done_d        = 1'b0;
               cnt_d         = '0;
               inner_d       = '0;
               outer_d       = '0;
               xof_restart_d = 1'b1;
               xof_outer_d   = '0;
               xof_inner_d   = '0;
`ifdef A_SAMPLER_STATS_EN
               rej_d         = '0;
               bcnt_d        = '0;
`endif
            end
         end
         SEED: begin
            state_d      = B0;
            byte_ready_d = 1'b1;
         end
         B0: begin
            byte_ready_d = 1'b1;
            if (hs) begin
               b0_d    = byte_in;
               state_d = B1;
            end
         end
         B1: begin
            byte_ready_d = 1'b1;
            if (hs) begin
               b1_d    = byte_in;
               state_d = B2;
            end
         end
         B2: begin
            byte_ready_d = 1'b1;
            if (hs) begin
               b2_d           = byte_in;
               state_d        = EMIT1;
               byte_ready_d   = 1'b0;
               write_enable_d = acc1;
               data_out_d     = {4'b0, d1};
               i_d            = cnt_q[7:0];
               if (acc1) cnt_d = cnt_q + 9'd1;
`ifdef A_SAMPLER_STATS_EN
               else if (rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
`endif
            end
         end
         EMIT1: begin
            state_d        = EMIT2;
            write_enable_d = acc2;
            data_out_d     = {4'b0, d2};
            i_d            = cnt_q[7:0];
            if (acc2) cnt_d = cnt_q + 9'd1;
`ifdef A_SAMPLER_STATS_EN
            else if (rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
`endif
         end
         EMIT2: begin
            if (cnt_q[8]) state_d = NEXT;
            else begin
               state_d      = B0;
               byte_ready_d = 1'b1;
            end
         end
         NEXT: begin
            cnt_d = '0;
            if (inner_q < KMAX) begin
               inner_d = inner_q + 3'd1;
               state_d = SEED;
            end else if (outer_q < KMAX) begin
               inner_d = '0;
               outer_d = outer_q + 3'd1;
               state_d = SEED;
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
            end
            if (state_d == SEED) begin
               xof_restart_d = 1'b1;
               xof_outer_d   = outer_d;
               xof_inner_d   = inner_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers; rst overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         b0_q           <= '0;
         b1_q           <= '0;
         b2_q           <= '0;
         cnt_q          <= '0;
         inner_q        <= '0;
         outer_q        <= '0;
         byte_ready_q   <= 1'b0;
         xof_restart_q  <= 1'b0;
         xof_outer_q    <= '0;
         xof_inner_q    <= '0;
         write_enable_q <= 1'b0;
         i_q            <= '0;
         data_out_q     <= '0;
         done_q         <= 1'b0;
`ifdef A_SAMPLER_STATS_EN
         rej_q          <= '0;
         bcnt_q         <= '0;
`endif
      end else begin
         state_q        <= state_d;
         b0_q           <= b0_d;
         b1_q           <= b1_d;
         b2_q           <= b2_d;
         cnt_q          <= cnt_d;
         inner_q        <= inner_d;
         outer_q        <= outer_d;
         byte_ready_q   <= byte_ready_d;
         xof_restart_q  <= xof_restart_d;
         xof_outer_q    <= xof_outer_d;
         xof_inner_q    <= xof_inner_d;
         write_enable_q <= write_enable_d;
         i_q            <= i_d;
         data_out_q     <= data_out_d;
         done_q         <= done_d;
`ifdef A_SAMPLER_STATS_EN
         rej_q          <= rej_d;
         bcnt_q         <= bcnt_d;
`endif
      end
   end

   assign byte_ready   = byte_ready_q;
   assign xof_restart  = xof_restart_q;
   assign xof_outer    = xof_outer_q;
   assign xof_inner    = xof_inner_q;
   assign write_enable = write_enable_q;
   assign i            = i_q;
   assign inner_loop   = inner_q;
   assign outer_loop   = outer_q;
   assign data_out     = data_out_q;
   assign done         = done_q;
`ifdef A_SAMPLER_STATS_EN
   assign reject_count = rej_q;
   assign byte_count   = bcnt_q;
`endif

endmodule
